// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan controller for an NDIG-digit common-cathode 7-segment display.
// One shared hex decoder is fed one nibble per slot through digit_val_o. A new display
// value is held in a pending register and only shown once the current frame has ended,
// so a frame never mixes old and new digits.
module seven_seg_scanner #(
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD        = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              lzb_i,
  input  logic              wr_en_i,
  input  logic [4*NDIG-1:0] wr_data_i,
  output logic [3:0]        digit_val_o,
  output logic [NDIG-1:0]   digit_sel_o,
  output logic              blank_o,
  output logic              frame_done_o,
  output logic              pending_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_C   = CNT_W'(DEAD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  typedef enum logic {
    DARK = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [4*NDIG-1:0] disp_q, disp_d;
  logic [4*NDIG-1:0] pend_q, pend_d;
  logic              pend_flag_q, pend_flag_d;

  logic [3:0]        digit_val_q, digit_val_d;
  logic [NDIG-1:0]   digit_sel_q, digit_sel_d;
  logic              blank_q, blank_d;
  logic              frame_done_q, frame_done_d;

  logic              slot_end;
  logic              boundary;
  logic              load_disp;
  logic              in_dead;
  logic              lead_zero;
  logic [3:0]        nib;
  logic [NDIG-1:0]   onehot;

  // Next-state: slot/digit counters, tear-free display hand-over and output decode.
  always_comb begin
    state_d      = en_i ? SCAN : DARK;
    slot_end     = (div_cnt_q == DIV_LAST);
    boundary     = en_i && slot_end && (idx_q == IDX_LAST);
    // Pending value moves to the display at a frame boundary, or at once while dark.
    load_disp    = pend_flag_q && (!en_i || boundary);

    div_cnt_d    = '0;
    idx_d        = '0;
    case (state_q)
      DARK: begin
        // Counters sit at zero while dark, so the first scanning cycle is slot 0, cycle 0.
        if (en_i) div_cnt_d = CNT_ONE;
      end
      SCAN: begin
        if (en_i) begin
          if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
            idx_d     = idx_q;
          end
        end
      end
      default: ;
    endcase

    disp_d      = load_disp ? pend_q : disp_q;
    pend_d      = wr_en_i ? wr_data_i : pend_q;
    // A write in the same cycle as the hand-over stays pending for the next frame.
    pend_flag_d = wr_en_i | (pend_flag_q & ~load_disp);

    nib       = disp_q[4*idx_q +: 4];
    in_dead   = (div_cnt_q < DEAD_C);
    onehot    = '0;
    onehot[idx_q] = 1'b1;
    // Digit idx is a leading zero when it and every more significant nibble are zero.
    lead_zero = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if ((i >= int'(idx_q)) && (disp_q[4*i +: 4] != 4'h0)) lead_zero = 1'b0;
    end

    if (en_i) begin
      digit_val_d  = nib;
      digit_sel_d  = in_dead ? '0 : onehot;
      blank_d      = in_dead || (lzb_i && (idx_q != '0) && lead_zero);
      frame_done_d = boundary;
    end else begin
      digit_val_d  = 4'h0;
      digit_sel_d  = '0;
      blank_d      = 1'b1;
      frame_done_d = 1'b0;
    end
  end

  // Single state register for the scan FSM, its counters, display storage and outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= DARK;
      div_cnt_q    <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_flag_q  <= 1'b0;
      digit_val_q  <= 4'h0;
      digit_sel_q  <= '0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_flag_q  <= pend_flag_d;
      digit_val_q  <= digit_val_d;
      digit_sel_q  <= digit_sel_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit_val_o  = digit_val_q;
  assign digit_sel_o  = digit_sel_q;
  assign blank_o      = blank_q;
  assign frame_done_o = frame_done_q;
  assign pending_o    = pend_flag_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Testbench for seven_seg_scanner: directed scenarios plus random traffic, every cycle
// compared against a frame-position model of the display.
module tb_seven_seg_scanner;

  localparam int NDIG = 4;
  localparam int RD   = 4;
  localparam int DEAD = 1;
  localparam int NRD  = NDIG * RD;

  logic        clk = 1'b0;
  logic        rst, en, lzb, wr_en;
  logic [15:0] wr_data;
  logic [3:0]  digit_val;
  logic [3:0]  digit_sel;
  logic        blank, frame_done, pending;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state: position within the frame, shown value, waiting value.
  int          m_pos  = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic        m_pf   = 1'b0;

  logic cur_en  = 1'b0;
  logic cur_lzb = 1'b0;

  seven_seg_scanner #(.NDIG(NDIG), .REFRESH_DIV(RD), .DEAD(DEAD)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .lzb_i       (lzb),
    .wr_en_i     (wr_en),
    .wr_data_i   (wr_data),
    .digit_val_o (digit_val),
    .digit_sel_o (digit_sel),
    .blank_o     (blank),
    .frame_done_o(frame_done),
    .pending_o   (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict outputs from the model, clock, update model, compare.
  task automatic step(input logic r, input logic e, input logic l, input logic w,
                      input logic [15:0] d);
    logic [3:0] ev, es;
    logic       eb, ef;
    int         slot, off;
    logic       fd_pos, load;
    rst = r; en = e; lzb = l; wr_en = w; wr_data = d;
    ev = 4'h0; es = 4'h0; eb = 1'b1; ef = 1'b0;
    if (!r && e) begin
      slot = m_pos / RD;
      off  = m_pos % RD;
      ev   = 4'((m_disp >> (4 * slot)) & 16'h000F);
      es   = (off < DEAD) ? 4'h0 : 4'(1 << slot);
      eb   = (off < DEAD) || (l && slot > 0 && ((m_disp >> (4 * slot)) == 16'h0));
      ef   = (m_pos == NRD - 1);
    end
    @(posedge clk);
    if (r) begin
      m_pos = 0; m_disp = '0; m_pend = '0; m_pf = 1'b0;
    end else begin
      fd_pos = e && (m_pos == NRD - 1);
      load   = m_pf && (!e || fd_pos);
      if (load) m_disp = m_pend;
      if (w) begin
        m_pend = d; m_pf = 1'b1;
      end else if (load) begin
        m_pf = 1'b0;
      end
      m_pos = e ? (m_pos + 1) % NRD : 0;
    end
    #1;
    cyc++;
    chk("digit_val", 32'(digit_val), 32'(ev));
    chk("digit_sel", 32'(digit_sel), 32'(es));
    chk("blank", 32'(blank), 32'(eb));
    chk("frame_done", 32'(frame_done), 32'(ef));
    chk("pending", 32'(pending), 32'(m_pf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, cur_en, cur_lzb, 1'b0, 16'h0);
  endtask

  task automatic write(input logic [15:0] d);
    step(1'b0, cur_en, cur_lzb, 1'b1, d);
  endtask

  // Bounded: with scanning enabled the model position always comes round within a frame.
  task automatic wait_pos(input int p);
    for (int i = 0; i < 2 * NRD && m_pos != p; i++) idle(1);
  endtask

  int         seen_a;
  logic [3:0] shown[$];

  initial begin
    rst = 1'b1; en = 1'b0; lzb = 1'b0; wr_en = 1'b0; wr_data = '0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("reset_blank", 32'(blank), 32'd1);
    chk("reset_sel", 32'(digit_sel), 32'd0);

    // First value waits a full frame, then scans 4,3,2,1
    cur_en = 1'b1;
    write(16'h1234);
    idle(14);
    chk("pending_before_fd", 32'(pending), 32'd1);
    idle(1);
    chk("first_frame_done", 32'(frame_done), 32'd1);
    chk("pending_after_fd", 32'(pending), 32'd0);
    for (int i = 0; i < NRD; i++) begin
      idle(1);
      if (digit_sel != 4'h0) shown.push_back(digit_val);
    end
    chk("shown_count", 32'(shown.size()), 32'd12);
    for (int i = 0; i < shown.size() && i < 12; i++) begin
      logic [15:0] ref_v;
      ref_v = 16'h1234;
      chk("shown_digit", 32'(shown[i]), 32'(ref_v[4*(i/3) +: 4]));
    end
    idle(8);

    // Leading-zero blanking: load through a dark cycle so it shows at once
    cur_en = 1'b0; cur_lzb = 1'b1;
    write(16'h0050);
    idle(2);
    cur_en = 1'b1;
    idle(2 * NRD);
    cur_en = 1'b0;
    write(16'h0000);
    idle(2);
    cur_en = 1'b1;
    idle(2 * NRD);
    cur_lzb = 1'b0;

    // Last write wins: AAAA never reaches the display
    wait_pos(2);
    write(16'hAAAA);
    idle(1);
    write(16'hBBBB);
    seen_a = 0;
    for (int i = 0; i < 3 * NRD; i++) begin
      idle(1);
      if (digit_val == 4'hA) seen_a++;
    end
    chk("aaaa_never_shown", 32'(seen_a), 32'd0);

    // Boundary write: DDDD shown first, CCCC a frame later
    wait_pos(NRD - 1);
    idle(1);
    write(16'hDDDD);
    wait_pos(NRD - 1);
    write(16'hCCCC);
    chk("pending_held_at_boundary", 32'(pending), 32'd1);
    idle(NRD);
    chk("pending_after_second_fd", 32'(pending), 32'd0);
    idle(2 * NRD);

    // en falls mid-slot, write while dark, en rises again
    wait_pos(5);
    cur_en = 1'b0;
    idle(1);
    chk("dark_sel", 32'(digit_sel), 32'd0);
    chk("dark_blank", 32'(blank), 32'd1);
    write(16'hE5E5);
    idle(2);
    cur_en = 1'b1;
    idle(2 * NRD);

    // Reset mid-frame discards a pending write
    wait_pos(3);
    write(16'h1111);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("rst_mid_pending", 32'(pending), 32'd0);
    chk("rst_mid_blank", 32'(blank), 32'd1);
    idle(3 * NRD);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, e, l, w;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 19) != 0);
      l = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 9) == 0);
      step(r, e, l, w, 16'($urandom) & (($urandom_range(0, 1) == 0) ? 16'h00FF : 16'hFFFF));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
